// File: rtl/alu181_nibble_sequencer_pkg.sv
// Shared definitions for the nibble-serial 74x181 sequencer: FSM encoding,
// slice width and the select codes callers commonly use.
package alu181_nibble_sequencer_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Active-high data select codes (M=0 for the arithmetic ones).
    localparam logic [3:0] SEL_ADD    = 4'b1001;
    localparam logic [3:0] SEL_SUB_M1 = 4'b0110;
    localparam logic [3:0] SEL_AND    = 4'b1011;

endpackage

// File: rtl/jeff_74x181.sv
// Behavioural 4-bit 74x181 ALU slice, active-high data, active-low carries.
// Purely combinational; P and G are the active-low group lookahead outputs.
module jeff_74x181 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       cn,
    output logic [3:0] f,
    output logic       cn4,
    output logic       aeqb,
    output logic       p,
    output logic       g
);

    logic [3:0] prop;
    logic [3:0] gen;
    logic [4:0] carry;

    always_comb begin
        prop     = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
        gen      = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
        carry    = 5'd0;
        carry[0] = ~cn;
        f        = 4'd0;
        for (int i = 0; i < 4; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
            // M=1 blocks the ripple so each bit becomes a pure logic function.
            f[i]       = m ? ~(prop[i] ^ gen[i]) : (prop[i] ^ gen[i] ^ carry[i]);
        end
        cn4  = ~carry[4];
        aeqb = &f;
        p    = ~(&prop);
        g    = ~(gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                 | (prop[3] & prop[2] & prop[1] & gen[0]));
    end

endmodule

// File: rtl/alu181_nibble_sequencer.sv
// Runs one NIBBLES*4-bit operation through a single 74x181 slice, one nibble
// per cycle LSB first, chaining the slice carry between nibbles.
module alu181_nibble_sequencer
    import alu181_nibble_sequencer_pkg::*;
#(
    parameter int NIBBLES = 4,
    localparam int W = NIBBLE_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    input  logic [3:0]   req_s,
    input  logic         req_m,
    input  logic         req_ci,
    output logic [3:0]   alu_a,
    output logic [3:0]   alu_b,
    output logic [3:0]   alu_s,
    output logic         alu_m,
    output logic         alu_ci,
    input  logic [3:0]   alu_f,
    input  logic         alu_co,
    input  logic         alu_aeqb,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_f,
    output logic         rsp_co,
    output logic         rsp_aeqb
);

    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    // Request handshake: an op transfers on a rising edge where req_valid and
    // req_ready are both high; a response transfers likewise on rsp_valid and
    // rsp_ready. Neither side may withdraw once valid is asserted.
    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [3:0]       s_q, s_d;
    logic             m_q, m_d;
    logic             ci_q, ci_d;
    logic [W-1:0]     f_q, f_d;
    logic             carry_q, carry_d;
    logic             aeqb_q, aeqb_d;

    logic [3:0] nib_a;
    logic [3:0] nib_b;

    always_comb begin
        nib_a = 4'd0;
        nib_b = 4'd0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_a = a_q[i*NIBBLE_W +: NIBBLE_W];
                nib_b = b_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    // The slice is only driven in RUN so it sees a quiet bus otherwise.
    always_comb begin
        alu_a  = 4'd0;
        alu_b  = 4'd0;
        alu_s  = 4'd0;
        alu_m  = 1'b0;
        alu_ci = 1'b0;
        if (state_q == ST_RUN) begin
            alu_a  = nib_a;
            alu_b  = nib_b;
            alu_s  = s_q;
            alu_m  = m_q;
            alu_ci = (idx_q == '0) ? ci_q : carry_q;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        m_d     = m_q;
        ci_d    = ci_q;
        f_d     = f_q;
        carry_d = carry_q;
        aeqb_d  = aeqb_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    s_d     = req_s;
                    m_d     = req_m;
                    ci_d    = req_ci;
                    idx_d   = '0;
                    aeqb_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        f_d[i*NIBBLE_W +: NIBBLE_W] = alu_f;
                    end
                end
                carry_d = alu_co;
                aeqb_d  = aeqb_q & alu_aeqb;
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            m_q     <= 1'b0;
            ci_q    <= 1'b0;
            f_q     <= '0;
            carry_q <= 1'b0;
            aeqb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            m_q     <= m_d;
            ci_q    <= ci_d;
            f_q     <= f_d;
            carry_q <= carry_d;
            aeqb_q  <= aeqb_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_f     = f_q;
    assign rsp_co    = carry_q;
    assign rsp_aeqb  = aeqb_q;

endmodule
